// File: rtl/simon_decrypt_iter.sv
// simon_decrypt_iter: iterative Simon32/64 block decryption core.
// A key handshake expands and stores all 32 round keys (28 cycles). Each block
// then runs one inverse round per cycle, consuming the keys k31..k0.
// Optional build macro SIMON_DEC_ENC_EN adds a 'mode' input. With mode=1 the
// core runs forward encryption (k0..k31) on the same key table.
//
// Handshake rule for every channel (key, in, out): a transfer happens on the
// rising clock edge where valid and ready are both high. Once valid is
// asserted, the sender holds it and its data stable until that edge. Ready may
// rise and fall independently of valid.
module simon_decrypt_iter #(
  parameter int ROUNDS = 32,
  parameter int WORD   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [4*WORD-1:0] key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*WORD-1:0] ciphertext,
`ifdef SIMON_DEC_ENC_EN
  input  logic              mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WORD-1:0] plaintext,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXPAND  = 3'd1,
    S_READY   = 3'd2,
    S_DECRYPT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // z0 sequence of the key schedule, bit for index 0 held in the MSB.
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [4:0] LAST_EXP  = 5'(ROUNDS - 5);
  localparam logic [4:0] LAST_RND  = 5'(ROUNDS - 1);

  state_t                       state_q;
  logic [4:0]                   cnt_q;
  logic [WORD-1:0]              x_q, y_q;
  logic [ROUNDS-1:0][WORD-1:0]  ks_q;
  logic                         out_valid_q;
`ifdef SIMON_DEC_ENC_EN
  logic                         mode_q;
`endif

  // Rotations are modulo WORD; s must lie in 1..WORD-1.
  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned s);
    rol = (v << s) | (v >> (WORD - s));
  endfunction

  function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
    simon_f = (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Key schedule: derive k[i+4] from the table, i = cnt_q.
  logic [WORD-1:0] k_i, k_i1, k_i3, kt_a, kt_b, knew_d;
  logic [5:0]      z_idx;
  logic            z_bit;

  // Combinational next key word for the current expansion step.
  always_comb begin
    k_i    = ks_q[cnt_q];
    k_i1   = ks_q[cnt_q + 5'd1];
    k_i3   = ks_q[cnt_q + 5'd3];
    z_idx  = 6'd61 - {1'b0, cnt_q};
    z_bit  = Z0[z_idx];
    kt_a   = rol(k_i3, WORD - 3) ^ k_i1;
    kt_b   = kt_a ^ rol(kt_a, WORD - 1);
    knew_d = ~k_i ^ kt_b ^ {{(WORD-1){1'b0}}, z_bit} ^ 16'h0003;
  end

  // Round datapath: inverse round by default, forward round when enabled.
  logic [WORD-1:0] rk, x_d, y_d;
  logic [4:0]      cnt_d;
  logic            last_round;

  // Combinational next x/y/counter for one round.
  always_comb begin
    rk         = ks_q[cnt_q];
    x_d        = y_q;
    y_d        = x_q ^ simon_f(y_q) ^ rk;
    cnt_d      = cnt_q - 5'd1;
    last_round = (cnt_q == 5'd0);
`ifdef SIMON_DEC_ENC_EN
    if (mode_q) begin
      x_d        = y_q ^ simon_f(x_q) ^ rk;
      y_d        = x_q;
      cnt_d      = cnt_q + 5'd1;
      last_round = (cnt_q == LAST_RND);
    end
`endif
  end

  // A new key always wins over a block offered in the same cycle.
  logic key_fire, in_fire;
  assign key_ready = (state_q == S_IDLE) || (state_q == S_READY);
  assign in_ready  = (state_q == S_READY) && !key_valid;
  assign key_fire  = key_valid && key_ready;
  assign in_fire   = in_valid && in_ready;
  assign busy      = (state_q == S_EXPAND) || (state_q == S_DECRYPT);
  assign out_valid = out_valid_q;
  assign plaintext = {x_q, y_q};

  // Control FSM plus key table, round registers and output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      x_q         <= '0;
      y_q         <= '0;
      ks_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef SIMON_DEC_ENC_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_READY: begin
          if (key_fire) begin
            ks_q[0] <= key[WORD-1:0];
            ks_q[1] <= key[2*WORD-1:WORD];
            ks_q[2] <= key[3*WORD-1:2*WORD];
            ks_q[3] <= key[4*WORD-1:3*WORD];
            cnt_q   <= 5'd0;
            state_q <= S_EXPAND;
          end else if (in_fire) begin
            x_q     <= ciphertext[2*WORD-1:WORD];
            y_q     <= ciphertext[WORD-1:0];
            cnt_q   <= LAST_RND;
`ifdef SIMON_DEC_ENC_EN
            mode_q  <= mode;
            if (mode) cnt_q <= 5'd0;
`endif
            state_q <= S_DECRYPT;
          end
        end
        S_EXPAND: begin
          ks_q[cnt_q + 5'd4] <= knew_d;
          if (cnt_q == LAST_EXP) begin
            cnt_q   <= 5'd0;
            state_q <= S_READY;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DECRYPT: begin
          x_q   <= x_d;
          y_q   <= y_d;
          cnt_q <= cnt_d;
          if (last_round) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_READY;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
